// File: rtl/tristate_bus_rx_if.sv
// Bus-side and consumer-side signals of the two-channel tri-state bus receiver.
// The receiver connects through the slave modport, and the driver/consumer through the master modport.
interface tristate_bus_rx_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             bus;
  logic             sel;
  logic [WIDTH-1:0] ch0_data;
  logic             ch0_valid;
  logic             ch0_ready;
  logic             ch0_ovf;
  logic [WIDTH-1:0] ch1_data;
  logic             ch1_valid;
  logic             ch1_ready;
  logic             ch1_ovf;

  modport master (
    output enable, bus, sel, ch0_ready, ch1_ready,
    input  ch0_data, ch0_valid, ch0_ovf, ch1_data, ch1_valid, ch1_ovf
  );

  modport slave (
    input  enable, bus, sel, ch0_ready, ch1_ready,
    output ch0_data, ch0_valid, ch0_ovf, ch1_data, ch1_valid, ch1_ovf
  );
endinterface

// File: rtl/tristate_bus_rx.sv
// Two-channel serial receiver on a shared strobe-qualified bus line. Words are assembled MSB-first,
// bus-idle timeout discards partial words, and there is a valid/ready output register per channel.
module tristate_bus_rx #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned IDLE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tristate_bus_rx_if.slave   bif
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned IW = 8;

  // Only WIDTH-1 accumulated bits are kept: the oldest bit of a full shift
  // register is shifted out on the completing edge and is never observable.
  logic [WIDTH-2:0] part_q [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [WIDTH-1:0] data_q [2];
  logic [IW-1:0]    idle_q;
  logic [1:0]       valid_q;
  logic [1:0]       ovf_q;
  logic [1:0]       ready;
  logic [1:0]       hit;
  logic [1:0]       done;
  logic [WIDTH-1:0] word;
  logic             flush;

  assign ready = {bif.ch1_ready, bif.ch0_ready};
  assign word  = {part_q[bif.sel], bif.bus};
  assign flush = bif.enable && (idle_q >= IW'(IDLE_MAX - 1));

  always_comb begin
    hit    = '0;
    done   = '0;
    hit[0] = ~bif.enable & ~bif.sel;
    hit[1] = ~bif.enable &  bif.sel;
    for (int unsigned c = 0; c < 2; c++) begin
      done[c] = hit[c] && (cnt_q[c] == CW'(WIDTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q  <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
      for (int unsigned c = 0; c < 2; c++) begin
        part_q[c] <= '0;
        cnt_q[c]  <= '0;
        data_q[c] <= '0;
      end
    end else begin
      if (bif.enable) begin
        if (idle_q != IW'(IDLE_MAX)) idle_q <= idle_q + 1'b1;
      end else begin
        idle_q <= '0;
      end

      for (int unsigned c = 0; c < 2; c++) begin
        if (flush) begin
          part_q[c] <= '0;
          cnt_q[c]  <= '0;
        end else if (hit[c]) begin
          part_q[c] <= word[WIDTH-2:0];
          cnt_q[c]  <= done[c] ? '0 : cnt_q[c] + 1'b1;
        end

        // A completion accepted in the same cycle as the pending word is consumed replaces it.
        if (done[c]) begin
          if (!valid_q[c] || ready[c]) begin
            data_q[c]  <= word;
            valid_q[c] <= 1'b1;
          end else begin
            ovf_q[c] <= 1'b1;
          end
        end else if (valid_q[c] && ready[c]) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  assign bif.ch0_data  = data_q[0];
  assign bif.ch0_valid = valid_q[0];
  assign bif.ch0_ovf   = ovf_q[0];
  assign bif.ch1_data  = data_q[1];
  assign bif.ch1_valid = valid_q[1];
  assign bif.ch1_ovf   = ovf_q[1];
endmodule

// File: doc/tristate_bus_rx.md
TRISTATE_BUS_RX -- requirements
Module: tristate_bus_rx

Interface
REQ-001 Parameter WIDTH, default 4, bits per received word per channel (legal 2..16).
REQ-002 Parameter IDLE_MAX, default 8, consecutive bus-released cycles that discard partial words (legal 1..255).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port enable  input  1  bus-driven strobe, active-low; bus sampled only when enable==0.
REQ-006 Port bus  input  1  shared tri-state data line; value ignored while enable==1.
REQ-007 Port sel  input  1  channel select qualifying each sampled bit: 0 -> channel 0, 1 -> channel 1.
REQ-008 Port ch0_data  output  WIDTH  last completed channel-0 word.
REQ-009 Port ch0_valid  output  1  ch0_data holds an unconsumed word.
REQ-010 Port ch0_ready  input  1  consumer accepts ch0_data when ch0_valid && ch0_ready.
REQ-011 Port ch0_ovf  output  1  sticky: a completed channel-0 word was dropped.
REQ-012 Ports ch1_data, ch1_valid, ch1_ready, ch1_ovf  same as REQ-008..REQ-011 for channel 1.

Function
REQ-013 Each channel has an independent WIDTH-bit shift register and a bit counter 0..WIDTH-1.
REQ-014 Rising edge with enable==0: bus shifted into channel sel MSB-first (sreg <= {sreg[WIDTH-2:0], bus}); that channel's counter increments; the other channel holds.
REQ-015 Rising edge with enable==1: no shift, no counter change on either channel; idle counter increments, saturating at IDLE_MAX.
REQ-016 Idle counter clears on any cycle with enable==0.
REQ-017 Idle counter reaching IDLE_MAX clears both bit counters and shift registers on that same edge; ch*_data/valid/ovf unaffected.
REQ-018 Word completion: sample taken with counter==WIDTH-1; counter wraps to 0 on that edge.
REQ-019 On completion with valid==0, or valid==1 and ready==1 the same cycle: ch_data <= completed word (including the bit just sampled), valid <= 1 on that edge (latency 1 cycle from final sample).
REQ-020 On completion with valid==1 and ready==0: word dropped, ch_data unchanged, valid stays 1, ch_ovf <= 1.
REQ-021 Handshake without completion: valid && ready -> valid <= 0 next edge; ch_data holds its value.
REQ-022 ready while valid==0 has no effect.
REQ-023 ch_data stable whenever valid==1 and no accepted completion occurs.
REQ-024 ovf clears only by reset.
REQ-025 Interleaved sel per bit is legal; each channel accumulates only its own bits in arrival order.
REQ-026 X/Z on bus while enable==0 is an upstream protocol error; captured value is undefined, no detection required.

Reset
REQ-027 rst_n==0 asynchronously clears shift registers, bit counters, idle counter, ch0_data, ch1_data to 0, ch0_valid, ch1_valid, ch0_ovf, ch1_ovf to 0.
REQ-028 Reset mid-word discards the partial word; first sample after rst_n release is bit 0 of a new word.
REQ-029 First rising edge with rst_n==1 operates normally; no extra wait cycle.

Verification
REQ-030 Basic: enable=0, sel=0, bus 1,0,1,1 on 4 edges -> ch0_data=4'b1011, ch0_valid=1 after 4th edge; ch1_valid stays 0.
REQ-031 Interleave: bits (sel,bus) (0,1)(1,0)(0,1)(1,0)(0,0)(1,1)(0,0)(1,1) -> ch0_data=4'b1100, ch1_data=4'b0011, both valid; ready=1 one cycle -> both valid=0.
REQ-032 Overflow: ch0_valid=1 with 4'hA, ready=0, new word 4'h5 completes -> ch0_data=4'hA, ch0_ovf=1; then ready=1 -> valid=0, ovf stays 1.
REQ-033 Simultaneous: ch0_valid=1 with 4'h3, ready=1 on the edge 4'hC completes -> ch0_data=4'hC, ch0_valid=1, ch0_ovf=0.
REQ-034 Idle flush: 2 channel-0 bits, enable=1 for 8 cycles, then 4 bits 0110 -> ch0_data=4'b0110; with 7 idle cycles instead -> ch0_data holds the 2 old bits followed by 01.
REQ-035 Reset mid-word: 3 bits shifted, rst_n pulsed low between edges -> all outputs 0 immediately; next 4 bits 1001 -> ch0_data=4'b1001.
